// File: rtl/fc_layer_engine_pkg.sv
// Shared definitions for the fully-connected layer engine: lane count, FSM encoding,
// per-layer ROM base addresses and the ReLU/saturation helper.
package fc_layer_engine_pkg;

    localparam int unsigned LANES         = 128;
    localparam int unsigned FC1_BASE_ADDR = 0;
    localparam int unsigned FC2_BASE_ADDR = 1152;

    typedef enum logic [1:0] {
        StFetch,
        StMac,
        StDone
    } fc_state_e;

    typedef struct packed {
        logic [63:0] value;
        logic        sat;
    } sat_result_t;

    // Optional ReLU, then clamp to a signed bit_w-wide range; sat flags a clamp.
    function automatic sat_result_t relu_saturate(input logic signed [63:0] r,
                                                  input int unsigned        bit_w,
                                                  input logic               relu);
        sat_result_t        res;
        logic signed [63:0] v;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v   = (64'sd1 <<< (bit_w - 1)) - 64'sd1;
        min_v   = -(64'sd1 <<< (bit_w - 1));
        v       = (relu && r < 0) ? 64'sd0 : r;
        res.sat = 1'b0;
        if (v > max_v) begin
            v       = max_v;
            res.sat = 1'b1;
        end else if (v < min_v) begin
            v       = min_v;
            res.sat = 1'b1;
        end
        res.value = v;
        return res;
    endfunction

endpackage

// File: rtl/fc_input_expand.sv
// Selects 128-element chunk 'chunk' of the input vector and widens each element to BIT bits.
module fc_input_expand
    import fc_layer_engine_pkg::*;
#(
    parameter int unsigned BIT    = 16,
    parameter int unsigned FRAC   = 8,
    parameter int unsigned IN_NUM = 1024,
    parameter int unsigned IN_BIT = 1,
    parameter int unsigned CW     = 4
) (
    input  logic [IN_NUM*IN_BIT-1:0] data_from_ram,
    input  logic [CW-1:0]            chunk,
    output logic [LANES*BIT-1:0]     opr2
);

    localparam int unsigned CHUNKS = IN_NUM / LANES;

    if (IN_BIT == 1) begin : g_binary
        // A set pixel becomes 1.0 in Q(BIT-FRAC).FRAC.
        localparam logic [BIT-1:0] ONE = {{(BIT-1){1'b0}}, 1'b1} << FRAC;

        always_comb begin
            opr2 = '0;
            if (chunk < CW'(CHUNKS)) begin
                for (int i = 0; i < LANES; i++) begin
                    opr2[i*BIT +: BIT] = data_from_ram[int'(chunk) * LANES + i] ? ONE : '0;
                end
            end
        end
    end else begin : g_wide
        always_comb begin
            opr2 = '0;
            if (chunk < CW'(CHUNKS)) begin
                for (int i = 0; i < LANES; i++) begin
                    opr2[i*BIT +: BIT] = data_from_ram[(int'(chunk) * LANES + i) * BIT +: BIT];
                end
            end
        end
    end

endmodule

// File: rtl/fc_layer_engine.sv
// Fully-connected layer engine: per neuron, MACs CHUNKS weight rows through the shared
// MultAdder, then adds the bias word, applies ReLU/saturation and stores the activation.
module fc_layer_engine
    import fc_layer_engine_pkg::*;
#(
    parameter int unsigned BIT       = 16,
    parameter int unsigned FRAC      = 8,
    parameter int unsigned IN_NUM    = 1024,
    parameter int unsigned IN_BIT    = 1,
    parameter int unsigned OUT_NUM   = 128,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned ADDR_W    = 11,
    parameter int unsigned RELU      = 1
) (
    input  logic                      clk,
    input  logic                      iRst_n,
    input  logic                      ena,
    input  logic [LANES*BIT-1:0]      data_from_rom,
    input  logic [IN_NUM*IN_BIT-1:0]  data_from_ram,
    input  logic [2*BIT-2:0]          data_from_MultAdder,
    input  logic                      overflow_from_MultAdder,
    output logic [ADDR_W-1:0]         addr_to_rom,
    output logic [LANES*BIT-1:0]      opr1_to_MultAdder,
    output logic [LANES*BIT-1:0]      opr2_to_MultAdder,
    output logic [OUT_NUM*BIT-1:0]    data_to_ram,
    output logic                      overflow,
    output logic                      done
);

    localparam int unsigned CHUNKS = IN_NUM / LANES;
    localparam int unsigned CW     = $clog2(CHUNKS + 1);
    localparam int unsigned NW     = (OUT_NUM > 1) ? $clog2(OUT_NUM) : 1;
    localparam int unsigned MW     = 2 * BIT - 1;
    localparam int unsigned ACC_W  = 2 * BIT + 4;

    fc_state_e               state_q;
    logic [NW-1:0]           n_q;
    logic [CW-1:0]           c_q;
    logic signed [ACC_W-1:0] acc_q;

    logic signed [ACC_W-1:0] mac_ext;
    logic signed [63:0]      acc_ext;
    logic signed [63:0]      bias_ext;
    logic signed [63:0]      r;
    sat_result_t             sat_res;
    logic                    last_chunk;
    logic                    last_neuron;

    assign addr_to_rom       = ADDR_W'(BASE_ADDR + int'(n_q) * (CHUNKS + 1) + int'(c_q));
    assign opr1_to_MultAdder = data_from_rom;

    fc_input_expand #(
        .BIT    (BIT),
        .FRAC   (FRAC),
        .IN_NUM (IN_NUM),
        .IN_BIT (IN_BIT),
        .CW     (CW)
    ) u_expand (
        .data_from_ram (data_from_ram),
        .chunk         (c_q),
        .opr2          (opr2_to_MultAdder)
    );

    assign last_chunk  = (c_q == CW'(CHUNKS));
    assign last_neuron = (n_q == NW'(OUT_NUM - 1));

    always_comb begin
        mac_ext  = {{(ACC_W - MW){data_from_MultAdder[MW-1]}}, data_from_MultAdder};
        acc_ext  = {{(64 - ACC_W){acc_q[ACC_W-1]}}, acc_q};
        // Bias lives in lane 0 of the word following the neuron's weight rows.
        bias_ext = {{(64 - BIT){data_from_rom[BIT-1]}}, data_from_rom[BIT-1:0]};
        r        = (acc_ext >>> FRAC) + bias_ext;
        sat_res  = relu_saturate(r, BIT, RELU != 0);
    end

    always_ff @(posedge clk) begin
        if (!iRst_n) begin
            state_q     <= StFetch;
            n_q         <= '0;
            c_q         <= '0;
            acc_q       <= '0;
            data_to_ram <= '0;
            overflow    <= 1'b0;
            done        <= 1'b0;
        end else if (ena) begin
            unique case (state_q)
                StFetch: state_q <= StMac;
                StMac: begin
                    if (!last_chunk) begin
                        acc_q    <= acc_q + mac_ext;
                        overflow <= overflow | overflow_from_MultAdder;
                        c_q      <= c_q + 1'b1;
                        state_q  <= StFetch;
                    end else begin
                        data_to_ram[int'(n_q) * BIT +: BIT] <= BIT'(sat_res.value);
                        overflow <= overflow | sat_res.sat;
                        acc_q    <= '0;
                        c_q      <= '0;
                        if (last_neuron) begin
                            done    <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            n_q     <= n_q + 1'b1;
                            state_q <= StFetch;
                        end
                    end
                end
                StDone:  state_q <= StDone;
                default: state_q <= StFetch;
            endcase
        end
    end

endmodule
